// File: rtl/ssd_scan_decoder_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan decoder.
// Segment patterns are seg[7:1] (a..g, active-low) with the dp bit dropped.
package ssd_scan_decoder_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned VAL_W = 4;
    localparam int unsigned DIG_N = 4;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    localparam logic [VAL_W-1:0] VAL_BLANK = 4'hF;
    localparam logic [VAL_W-1:0] VAL_ERR   = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_e;

    typedef struct packed {
        logic [VAL_W-1:0] val;
        logic             dp;
        logic             err;
    } slot_t;

    // A ctrl sample is usable only when exactly one digit enable is low.
    function automatic logic ctrl_is_valid(input logic [DIG_N-1:0] c);
        case (c)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] ctrl_slot(input logic [DIG_N-1:0] c);
        case (c)
            4'b1110: return 2'd0;
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/ssd_scan_decoder_pattern_decode.sv
// Combinational seven-segment pattern to digit value decoder.
module ssd_pattern_decode
    import ssd_scan_decoder_pkg::*;
(
    input  logic [SEG_W-1:0] seg_i,
    output logic [VAL_W-1:0] value_o,
    output logic             err_o
);

    always_comb begin
        value_o = VAL_ERR;
        err_o   = 1'b1;
        case (seg_i)
            SEG_0:     begin value_o = 4'd0;      err_o = 1'b0; end
            SEG_1:     begin value_o = 4'd1;      err_o = 1'b0; end
            SEG_2:     begin value_o = 4'd2;      err_o = 1'b0; end
            SEG_3:     begin value_o = 4'd3;      err_o = 1'b0; end
            SEG_4:     begin value_o = 4'd4;      err_o = 1'b0; end
            SEG_5:     begin value_o = 4'd5;      err_o = 1'b0; end
            SEG_6:     begin value_o = 4'd6;      err_o = 1'b0; end
            SEG_7:     begin value_o = 4'd7;      err_o = 1'b0; end
            SEG_8:     begin value_o = 4'd8;      err_o = 1'b0; end
            SEG_9:     begin value_o = 4'd9;      err_o = 1'b0; end
            SEG_BLANK: begin value_o = VAL_BLANK; err_o = 1'b0; end
            default:   begin value_o = VAL_ERR;   err_o = 1'b1; end
        endcase
    end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Recovers the four digits shown on a scanned, active-low seven-segment display
// by debouncing each digit enable, collecting a full frame, and flagging timeouts.
module ssd_scan_decoder
    import ssd_scan_decoder_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIG_N-1:0] ssd_ctrl,
    input  logic [7:0]       ssd_out,
    output logic [VAL_W-1:0] dig_0,
    output logic [VAL_W-1:0] dig_1,
    output logic [VAL_W-1:0] dig_2,
    output logic [VAL_W-1:0] dig_3,
    output logic [DIG_N-1:0] dp,
    output logic             frame_valid,
    output logic             seg_err,
    output logic             stale
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned TO_W  = 24;
    localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);

    logic [DIG_N-1:0]            ctrl_q, ctrl_prev_q;
    logic [7:0]                  seg_q, seg_prev_q;
    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [TO_W-1:0]             tcnt_q, tcnt_d, tcnt_inc;
    logic [DIG_N-1:0]            seen_q, seen_d, seen_new;
    slot_t [DIG_N-1:0]           shadow_q, shadow_d;
    logic [DIG_N-1:0][VAL_W-1:0] dig_q, dig_d;
    logic [DIG_N-1:0]            dp_q, dp_d;
    logic                        fv_q, fv_d;
    logic                        err_q, err_d;
    logic                        stale_q, stale_d;

    logic                        accept_c;
    logic                        start_c;
    logic                        changed_c;
    logic                        valid_c;
    logic                        to_hit_c;
    logic [1:0]                  slot_c;
    logic [VAL_W-1:0]            dec_val;
    logic                        dec_err;

    ssd_pattern_decode u_decode (
        .seg_i   (seg_q[7:1]),
        .value_o (dec_val),
        .err_o   (dec_err)
    );

    assign valid_c   = ctrl_is_valid(ctrl_q);
    assign slot_c    = ctrl_slot(ctrl_q);
    assign changed_c = (ctrl_q != ctrl_prev_q) || (seg_q != seg_prev_q);

    // Stability FSM: a digit is accepted after STABLE_CYCLES identical samples.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_c = 1'b0;
        start_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_c) start_c = 1'b1;
            end
            ST_SETTLE: begin
                if (!changed_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == STABLE_C) begin
                        accept_c = 1'b1;
                        state_d  = ST_HELD;
                    end
                end else if (valid_c) begin
                    start_c = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_HELD: begin
                if (changed_c) begin
                    if (valid_c) begin
                        start_c = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // First sample of a new digit counts as one; a threshold of one accepts at once.
        if (start_c) begin
            cnt_d = CNT_W'(1);
            if (STABLE_C == CNT_W'(1)) begin
                accept_c = 1'b1;
                state_d  = ST_HELD;
            end else begin
                state_d = ST_SETTLE;
            end
        end
    end

    // Shadow slots, frame assembly and frame timeout.
    always_comb begin
        shadow_d = shadow_q;
        seen_d   = seen_q;
        dig_d    = dig_q;
        dp_d     = dp_q;
        err_d    = err_q;
        fv_d     = 1'b0;
        stale_d  = stale_q;
        tcnt_inc = (tcnt_q == TO_MAX) ? TO_MAX : tcnt_q + TO_W'(1);
        to_hit_c = (tcnt_inc == TO_MAX);
        tcnt_d   = tcnt_inc;
        seen_new = seen_q | (DIG_N'(1) << slot_c);
        if (accept_c) begin
            shadow_d[slot_c] = '{val: dec_val, dp: ~seg_q[0], err: dec_err};
            if (seen_new == {DIG_N{1'b1}}) begin
                err_d = 1'b0;
                for (int i = 0; i < int'(DIG_N); i++) begin
                    dig_d[i] = shadow_d[i].val;
                    dp_d[i]  = shadow_d[i].dp;
                    err_d    = err_d | shadow_d[i].err;
                end
                fv_d    = 1'b1;
                seen_d  = '0;
                tcnt_d  = '0;
                stale_d = 1'b0;
            end else begin
                seen_d = seen_new;
                // An accept landing on the timeout keeps its slot and restarts the timer.
                if (to_hit_c) tcnt_d = '0;
            end
        end else if (to_hit_c) begin
            stale_d = 1'b1;
            seen_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q      <= '0;
            seg_q       <= '0;
            ctrl_prev_q <= '0;
            seg_prev_q  <= '0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tcnt_q      <= '0;
            seen_q      <= '0;
            shadow_q    <= '0;
            dig_q       <= '0;
            dp_q        <= '0;
            fv_q        <= 1'b0;
            err_q       <= 1'b0;
            stale_q     <= 1'b1;
        end else begin
            ctrl_q      <= ssd_ctrl;
            seg_q       <= ssd_out;
            ctrl_prev_q <= ctrl_q;
            seg_prev_q  <= seg_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tcnt_q      <= tcnt_d;
            seen_q      <= seen_d;
            shadow_q    <= shadow_d;
            dig_q       <= dig_d;
            dp_q        <= dp_d;
            fv_q        <= fv_d;
            err_q       <= err_d;
            stale_q     <= stale_d;
        end
    end

    assign dig_0       = dig_q[0];
    assign dig_1       = dig_q[1];
    assign dig_2       = dig_q[2];
    assign dig_3       = dig_q[3];
    assign dp          = dp_q;
    assign frame_valid = fv_q;
    assign seg_err     = err_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Directed bench for ssd_scan_decoder: scan frames, debounce, errors, timeout, reset.
module tb_ssd_scan_decoder;

    logic       clk;
    logic       reset;
    logic [3:0] ssd_ctrl;
    logic [7:0] ssd_out;
    logic [3:0] dig_0, dig_1, dig_2, dig_3;
    logic [3:0] dp;
    logic       frame_valid;
    logic       seg_err;
    logic       stale;

    int pass_cnt = 0;
    int total    = 0;
    int fv_count = 0;
    int fv_long  = 0;
    logic fv_prev = 1'b0;

    ssd_scan_decoder #(
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ssd_ctrl    (ssd_ctrl),
        .ssd_out     (ssd_out),
        .dig_0       (dig_0),
        .dig_1       (dig_1),
        .dig_2       (dig_2),
        .dig_3       (dig_3),
        .dp          (dp),
        .frame_valid (frame_valid),
        .seg_err     (seg_err),
        .stale       (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts frame_valid pulses and any pulse longer than one cycle.
    always @(negedge clk) begin
        if (frame_valid) begin
            fv_count = fv_count + 1;
            if (fv_prev) fv_long = fv_long + 1;
        end
        fv_prev = frame_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, required < 200000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic scan(input logic [3:0] c, input logic [7:0] s, input int n);
        ssd_ctrl = c;
        ssd_out  = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan_1234(input int n);
        scan(4'hE, 8'h99, n);
        scan(4'hD, 8'h0D, n);
        scan(4'hB, 8'h25, n);
        scan(4'h7, 8'h9F, n);
    endtask

    function automatic logic [15:0] digs();
        return {dig_3, dig_2, dig_1, dig_0};
    endfunction

    task automatic test_reset;
        reset    = 1'b0;
        ssd_ctrl = 4'hF;
        ssd_out  = 8'hFF;
        repeat (3) @(negedge clk);
        total++; if (digs() !== 16'h0000) $display("FAIL reset_digs: got %h want 0000", digs()); else pass_cnt++;
        total++; if (dp !== 4'b0000) $display("FAIL reset_dp: got %b want 0000", dp); else pass_cnt++;
        total++; if (frame_valid !== 1'b0) $display("FAIL reset_fv: got %b want 0", frame_valid); else pass_cnt++;
        total++; if (seg_err !== 1'b0) $display("FAIL reset_seg_err: got %b want 0", seg_err); else pass_cnt++;
        total++; if (stale !== 1'b1) $display("FAIL reset_stale: got %b want 1", stale); else pass_cnt++;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_scan_1234;
        int start;
        start = fv_count;
        scan_1234(8);
        scan(4'hF, 8'hFF, 2);
        @(negedge clk);
        total++; if (fv_count - start !== 1) $display("FAIL scan_fv_pulses: got %0d want 1", fv_count - start); else pass_cnt++;
        total++; if (fv_long !== 0) $display("FAIL scan_fv_width: got %0d long pulses want 0", fv_long); else pass_cnt++;
        total++; if (digs() !== 16'h1234) $display("FAIL scan_digs: got %h want 1234", digs()); else pass_cnt++;
        total++; if (dp !== 4'b0000) $display("FAIL scan_dp: got %b want 0000", dp); else pass_cnt++;
        total++; if (seg_err !== 1'b0) $display("FAIL scan_seg_err: got %b want 0", seg_err); else pass_cnt++;
        total++; if (stale !== 1'b0) $display("FAIL scan_stale: got %b want 0", stale); else pass_cnt++;
    endtask

    task automatic test_dp;
        int start;
        start = fv_count;
        scan(4'hE, 8'h99, 8);
        scan(4'hD, 8'h0D, 8);
        scan(4'hB, 8'h24, 8);
        scan(4'h7, 8'h9F, 8);
        scan(4'hF, 8'hFF, 2);
        @(negedge clk);
        total++; if (fv_count - start !== 1) $display("FAIL dp_fv_pulses: got %0d want 1", fv_count - start); else pass_cnt++;
        total++; if (digs() !== 16'h1234) $display("FAIL dp_digs: got %h want 1234", digs()); else pass_cnt++;
        total++; if (dp !== 4'b0100) $display("FAIL dp_bits: got %b want 0100", dp); else pass_cnt++;
    endtask

    task automatic test_seg_err;
        scan(4'hE, 8'h99, 8);
        scan(4'hD, 8'h6F, 8);
        scan(4'hB, 8'h25, 8);
        scan(4'h7, 8'h9F, 8);
        scan(4'hF, 8'hFF, 2);
        @(negedge clk);
        total++; if (digs() !== 16'h12E4) $display("FAIL err_digs: got %h want 12e4", digs()); else pass_cnt++;
        total++; if (seg_err !== 1'b1) $display("FAIL err_flag: got %b want 1", seg_err); else pass_cnt++;
        total++; if (dp !== 4'b0000) $display("FAIL err_dp: got %b want 0000", dp); else pass_cnt++;
        // Clean frame with a blank leftmost digit clears the error.
        scan(4'hE, 8'h01, 8);
        scan(4'hD, 8'h1F, 8);
        scan(4'hB, 8'h41, 8);
        scan(4'h7, 8'hFF, 8);
        scan(4'hF, 8'hFF, 2);
        @(negedge clk);
        total++; if (digs() !== 16'hF678) $display("FAIL clean_digs: got %h want f678", digs()); else pass_cnt++;
        total++; if (seg_err !== 1'b0) $display("FAIL clean_err_flag: got %b want 0", seg_err); else pass_cnt++;
    endtask

    task automatic test_glitch;
        int start;
        start = fv_count;
        scan(4'hE, 8'h49, 8);
        scan(4'hC, 8'h00, 2);
        scan(4'hD, 8'h09, 8);
        scan(4'hC, 8'h00, 2);
        scan(4'hB, 8'h03, 8);
        scan(4'h7, 8'h0D, 8);
        scan(4'hF, 8'hFF, 2);
        @(negedge clk);
        total++; if (fv_count - start !== 1) $display("FAIL glitch_fv_pulses: got %0d want 1", fv_count - start); else pass_cnt++;
        total++; if (digs() !== 16'h3095) $display("FAIL glitch_digs: got %h want 3095", digs()); else pass_cnt++;
    endtask

    task automatic test_short_hold;
        int start;
        @(negedge clk);
        total++; if (stale !== 1'b0) $display("FAIL short_pre_stale: got %b want 0", stale); else pass_cnt++;
        #1;
        start = fv_count;
        for (int r = 0; r < 12; r++) begin
            scan(4'hE, 8'h99, 3);
            scan(4'hD, 8'h0D, 3);
            scan(4'hB, 8'h25, 3);
            scan(4'h7, 8'h9F, 3);
        end
        @(negedge clk);
        total++; if (fv_count - start !== 0) $display("FAIL short_fv_pulses: got %0d want 0", fv_count - start); else pass_cnt++;
        total++; if (stale !== 1'b1) $display("FAIL short_stale: got %b want 1", stale); else pass_cnt++;
        total++; if (digs() !== 16'h3095) $display("FAIL short_digs_held: got %h want 3095", digs()); else pass_cnt++;
        total++; if (dp !== 4'b0000) $display("FAIL short_dp_held: got %b want 0000", dp); else pass_cnt++;
        total++; if (seg_err !== 1'b0) $display("FAIL short_err_held: got %b want 0", seg_err); else pass_cnt++;
        #1;
        scan_1234(8);
        scan(4'hF, 8'hFF, 2);
        @(negedge clk);
        total++; if (stale !== 1'b0) $display("FAIL recover_stale: got %b want 0", stale); else pass_cnt++;
        total++; if (digs() !== 16'h1234) $display("FAIL recover_digs: got %h want 1234", digs()); else pass_cnt++;
    endtask

    task automatic test_reset_midframe;
        int start;
        #1;
        scan(4'hE, 8'h01, 8);
        scan(4'hD, 8'h01, 8);
        #3;
        reset = 1'b0;
        #1;
        total++; if (stale !== 1'b1) $display("FAIL midreset_stale: got %b want 1", stale); else pass_cnt++;
        total++; if (digs() !== 16'h0000) $display("FAIL midreset_digs: got %h want 0000", digs()); else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        start = fv_count;
        scan(4'hB, 8'h25, 8);
        scan(4'h7, 8'h9F, 8);
        @(negedge clk);
        total++; if (fv_count - start !== 0) $display("FAIL midreset_partial_fv: got %0d want 0", fv_count - start); else pass_cnt++;
        #1;
        scan(4'hE, 8'h99, 8);
        scan(4'hD, 8'h0D, 8);
        scan(4'hF, 8'hFF, 2);
        @(negedge clk);
        total++; if (fv_count - start !== 1) $display("FAIL midreset_full_fv: got %0d want 1", fv_count - start); else pass_cnt++;
        total++; if (digs() !== 16'h1234) $display("FAIL midreset_digs_after: got %h want 1234", digs()); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_scan_1234();
        test_dp();
        test_seg_err();
        test_glitch();
        test_short_hold();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
